sar_adc_ctrl_param: RTL and testbench



---
 rtl/sar_adc_pkg.sv | 26 ++
 rtl/sar_adc_sar_reg.sv | 51 +++++
 rtl/sar_adc_ctrl_param.sv | 162 ++++++++++++++++
 tb/tb_sar_adc_ctrl_param.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/sar_adc_pkg.sv
// Shared types and width helpers for the parametrised SAR ADC controller.
package sar_adc_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SAMPLE  = 2'd1,
        CONVERT = 2'd2,
        DONE    = 2'd3
    } sar_state_e;

    // Accumulator width: RES_BITS + AVG_LOG2 holds 2^AVG_LOG2 full-scale codes.
    function automatic int acc_width(input int res_bits, input int avg_log2);
        return res_bits + avg_log2;
    endfunction

    function automatic int cnt_width(input int sample_cycles);
        int w;
        w = $clog2(sample_cycles);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic int avg_cnt_width(input int avg_log2);
        return (avg_log2 < 1) ? 1 : avg_log2;
    endfunction

endpackage

// File: rtl/sar_adc_sar_reg.sv
// Successive-approximation register with bit-index counter and trial-code generation.
module sar_adc_sar_reg #(
    parameter int RES_BITS = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic                step,
    input  logic                cmp,
    output logic [RES_BITS-1:0] trial_code,
    output logic [RES_BITS-1:0] final_code,
    output logic                last_bit
);

    localparam int KW = $clog2(RES_BITS);

    logic [RES_BITS-1:0] sar_q, sar_d;
    logic [RES_BITS-1:0] bit_mask;
    logic [KW-1:0]       k_q, k_d;

    always_comb begin
        bit_mask   = {{(RES_BITS-1){1'b0}}, 1'b1} << k_q;
        trial_code = sar_q | bit_mask;
        // Bit k of sar_q is still clear, so keeping the trial bit equals sar_q[k] <= cmp.
        final_code = cmp ? trial_code : sar_q;
        last_bit   = (k_q == '0);
    end

    always_comb begin
        sar_d = sar_q;
        k_d   = k_q;
        if (load) begin
            sar_d = '0;
            k_d   = KW'(RES_BITS - 1);
        end else if (step) begin
            sar_d = final_code;
            k_d   = k_q - KW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sar_q <= '0;
            k_q   <= '0;
        end else begin
            sar_q <= sar_d;
            k_q   <= k_d;
        end
    end

endmodule

// File: rtl/sar_adc_ctrl_param.sv
// SAR ADC controller: sample timing, SAR search, optional 2^AVG_LOG2 averaging.
// Optional macro SAR_ADC_CTRL_OFFSET_EN adds a signed, saturating result offset.
module sar_adc_ctrl_param
    import sar_adc_pkg::*;
#(
    parameter int RES_BITS      = 5,
    parameter int SAMPLE_CYCLES = 2,
    parameter int AVG_LOG2      = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                go,
    input  logic                cont,
    input  logic                cmp,
`ifdef SAR_ADC_CTRL_OFFSET_EN
    input  logic [RES_BITS-1:0] offset,
`endif
    output logic                sample,
    output logic [RES_BITS-1:0] dac_code,
    output logic [RES_BITS-1:0] result,
    output logic                valid,
    output logic                busy
);

    localparam int ACC_W     = acc_width(RES_BITS, AVG_LOG2);
    localparam int CNT_W     = cnt_width(SAMPLE_CYCLES);
    localparam int AVG_CNT_W = avg_cnt_width(AVG_LOG2);

    sar_state_e            state_q, state_d;
    logic [CNT_W-1:0]      samp_cnt_q, samp_cnt_d;
    logic [AVG_CNT_W-1:0]  avg_cnt_q, avg_cnt_d;
    logic [ACC_W-1:0]      acc_q, acc_d;
    logic [RES_BITS-1:0]   result_q, result_d;

    logic                  samp_last, avg_last;
    logic                  sar_load, sar_step, last_bit;
    logic [RES_BITS-1:0]   trial_code, final_code;
    logic [ACC_W-1:0]      acc_sum;
    logic [RES_BITS-1:0]   avg_val, res_val;

    assign samp_last = (samp_cnt_q == CNT_W'(SAMPLE_CYCLES - 1));
    assign avg_last  = (avg_cnt_q == AVG_CNT_W'((1 << AVG_LOG2) - 1));

    sar_adc_sar_reg #(
        .RES_BITS(RES_BITS)
    ) u_sar_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (sar_load),
        .step      (sar_step),
        .cmp       (cmp),
        .trial_code(trial_code),
        .final_code(final_code),
        .last_bit  (last_bit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (go) state_d = SAMPLE;
            SAMPLE:  if (samp_last) state_d = CONVERT;
            CONVERT: if (last_bit) state_d = avg_last ? DONE : SAMPLE;
            DONE:    state_d = cont ? SAMPLE : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sample   = (state_q == SAMPLE);
        busy     = (state_q != IDLE);
        valid    = (state_q == DONE);
        dac_code = (state_q == CONVERT) ? trial_code : '0;
        sar_load = (state_q == SAMPLE) && samp_last;
        sar_step = (state_q == CONVERT);
    end

    always_comb begin
        acc_sum = acc_q + ACC_W'(final_code);
        avg_val = RES_BITS'(acc_sum >> AVG_LOG2);
    end

`ifdef SAR_ADC_CTRL_OFFSET_EN
    // Two guard bits: top bit flags a negative sum, next bit flags overflow past full scale.
    logic [RES_BITS+1:0] off_sum;
    always_comb begin
        off_sum = {2'b00, avg_val} + {{2{offset[RES_BITS-1]}}, offset};
        if (off_sum[RES_BITS+1]) begin
            res_val = '0;
        end else if (off_sum[RES_BITS]) begin
            res_val = '1;
        end else begin
            res_val = off_sum[RES_BITS-1:0];
        end
    end
`else
    assign res_val = avg_val;
`endif

    always_comb begin
        samp_cnt_d = samp_cnt_q;
        avg_cnt_d  = avg_cnt_q;
        acc_d      = acc_q;
        result_d   = result_q;
        case (state_q)
            IDLE: begin
                if (go) begin
                    samp_cnt_d = '0;
                    avg_cnt_d  = '0;
                    acc_d      = '0;
                end
            end
            SAMPLE: begin
                samp_cnt_d = samp_last ? '0 : samp_cnt_q + CNT_W'(1);
            end
            CONVERT: begin
                if (last_bit) begin
                    acc_d = acc_sum;
                    if (avg_last) begin
                        result_d = res_val;
                    end else begin
                        avg_cnt_d = avg_cnt_q + AVG_CNT_W'(1);
                    end
                end
            end
            DONE: begin
                if (cont) begin
                    samp_cnt_d = '0;
                    avg_cnt_d  = '0;
                    acc_d      = '0;
                end
            end
            default: begin
                samp_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            samp_cnt_q <= '0;
            avg_cnt_q  <= '0;
            acc_q      <= '0;
            result_q   <= '0;
        end else begin
            samp_cnt_q <= samp_cnt_d;
            avg_cnt_q  <= avg_cnt_d;
            acc_q      <= acc_d;
            result_q   <= result_d;
        end
    end

    assign result = result_q;

endmodule

// File: tb/tb_sar_adc_ctrl_param.sv
// Directed bench for sar_adc_ctrl_param: single-shot, boundaries, continuous, averaging, reset.
module tb_sar_adc_ctrl_param;

    logic       clk = 1'b0;
    logic       rst;
    logic       go, cont;
    logic [4:0] vin1;
    logic       cmp1, sample1, valid1, busy1;
    logic [4:0] dac1, result1;

    logic       go2;
    logic       cont2 = 1'b0;
    logic [4:0] vin2 = 5'd0;
    logic       cmp2, sample2, valid2, busy2;
    logic [4:0] dac2, result2;
    logic [4:0] avg_tab [4] = '{5'd10, 5'd11, 5'd11, 5'd12};
    int         pulse_cnt2 = 0;

`ifdef SAR_ADC_CTRL_OFFSET_EN
    logic [4:0] offset1;
    logic [4:0] offset2 = 5'd0;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Comparator model: 1 when the input voltage is at or above the trial code.
    assign cmp1 = (vin1 >= dac1);
    assign cmp2 = (vin2 >= dac2);

    always @(posedge sample2) begin
        vin2 = avg_tab[pulse_cnt2 % 4];
        pulse_cnt2++;
    end

    sar_adc_ctrl_param #(.RES_BITS(5), .SAMPLE_CYCLES(2), .AVG_LOG2(0)) u_dut (
        .clk(clk), .rst(rst), .go(go), .cont(cont), .cmp(cmp1),
`ifdef SAR_ADC_CTRL_OFFSET_EN
        .offset(offset1),
`endif
        .sample(sample1), .dac_code(dac1), .result(result1), .valid(valid1), .busy(busy1)
    );

    sar_adc_ctrl_param #(.RES_BITS(5), .SAMPLE_CYCLES(2), .AVG_LOG2(2)) u_avg (
        .clk(clk), .rst(rst), .go(go2), .cont(cont2), .cmp(cmp2),
`ifdef SAR_ADC_CTRL_OFFSET_EN
        .offset(offset2),
`endif
        .sample(sample2), .dac_code(dac2), .result(result2), .valid(valid2), .busy(busy2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string tag, input int limit, output int n);
        n = 0;
        while (valid1 !== 1'b1 && n < limit) begin
            tick();
            n++;
        end
        check(tag, valid1, 1);
    endtask

    // seq packs the five expected trial codes MSB-trial first.
    task automatic single_conv(input logic [4:0] v, input logic [24:0] seq, input logic [4:0] exp_res);
        vin1 = v;
        go   = 1'b1;
        tick();
        go   = 1'b0;
        check("samp_first", sample1, 1);
        check("busy_first", busy1, 1);
        check("dac_in_sample", dac1, 0);
        tick();
        check("samp_second", sample1, 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("samp_low_conv", sample1, 0);
            check("dac_trial", dac1, seq[24-5*i -: 5]);
            check("no_early_valid", valid1, 0);
        end
        tick();
        check("valid_strobe", valid1, 1);
        check("result_at_valid", result1, exp_res);
        check("dac_in_done", dac1, 0);
        tick();
        check("valid_one_cycle", valid1, 0);
        check("busy_after_done", busy1, 0);
        check("result_held", result1, exp_res);
    endtask

    initial begin
        int n, vcnt, bcnt;
        logic [4:0] cap;
        rst  = 1'b1;
        go   = 1'b0;
        go2  = 1'b0;
        cont = 1'b0;
        vin1 = 5'd0;
`ifdef SAR_ADC_CTRL_OFFSET_EN
        offset1 = 5'd0;
`endif
        tick();
        tick();
        check("rst_sample", sample1, 0);
        check("rst_dac", dac1, 0);
        check("rst_result", result1, 0);
        check("rst_valid", valid1, 0);
        check("rst_busy", busy1, 0);
        rst = 1'b0;
        tick();
        tick();
        check("idle_no_go_busy", busy1, 0);

        single_conv(5'd19, {5'd16, 5'd24, 5'd20, 5'd18, 5'd19}, 5'd19);
        single_conv(5'd0,  {5'd16, 5'd8,  5'd4,  5'd2,  5'd1},  5'd0);
        single_conv(5'd31, {5'd16, 5'd24, 5'd28, 5'd30, 5'd31}, 5'd31);

        // Continuous mode, then drop cont with a stray go while busy.
        vin1 = 5'd7;
        cont = 1'b1;
        go   = 1'b1;
        tick();
        go   = 1'b0;
        wait_valid("cont_first_valid", 20, n);
        check("cont_first_result", result1, 7);
        for (int r = 0; r < 2; r++) begin
            tick();
            wait_valid("cont_next_valid", 20, n);
            check("cont_period", n + 1, 8);
            check("cont_result", result1, 7);
        end
        repeat (3) tick();
        cont = 1'b0;
        go   = 1'b1;
        repeat (2) tick();
        go   = 1'b0;
        wait_valid("cont_last_valid", 20, n);
        check("cont_last_result", result1, 7);
        tick();
        check("cont_stop_valid", valid1, 0);
        check("cont_stop_busy", busy1, 0);
        vcnt = 0;
        bcnt = 0;
        repeat (20) begin
            tick();
            vcnt += int'(valid1);
            bcnt += int'(busy1);
        end
        check("cont_no_extra_valid", vcnt, 0);
        check("cont_no_restart", bcnt, 0);

        // Averaging instance: four conversions of 10, 11, 11, 12.
        check("avg_result_init", result2, 0);
        go2 = 1'b1;
        tick();
        go2 = 1'b0;
        vcnt = 0;
        cap  = 5'd0;
        repeat (40) begin
            tick();
            if (valid2 === 1'b1) begin
                vcnt++;
                cap = result2;
            end
        end
        check("avg_valid_count", vcnt, 1);
        check("avg_result", cap, 11);
        check("avg_sample_pulses", pulse_cnt2, 4);
        check("avg_idle_after", busy2, 0);

        // Asynchronous reset during CONVERT bit 2.
        vin1 = 5'd19;
        go   = 1'b1;
        tick();
        go   = 1'b0;
        repeat (4) tick();
        check("pre_rst_dac", dac1, 20);
        rst = 1'b1;
        #1;
        check("async_rst_sample", sample1, 0);
        check("async_rst_dac", dac1, 0);
        check("async_rst_result", result1, 0);
        check("async_rst_valid", valid1, 0);
        check("async_rst_busy", busy1, 0);
        tick();
        rst = 1'b0;
        vcnt = 0;
        bcnt = 0;
        repeat (20) begin
            tick();
            vcnt += int'(valid1);
            bcnt += int'(busy1);
        end
        check("post_rst_no_valid", vcnt, 0);
        check("post_rst_idle", bcnt, 0);

`ifdef SAR_ADC_CTRL_OFFSET_EN
        offset1 = 5'd5;
        single_conv(5'd30, {5'd16, 5'd24, 5'd28, 5'd30, 5'd31}, 5'd31);
        offset1 = 5'b11100;
        single_conv(5'd2,  {5'd16, 5'd8,  5'd4,  5'd2,  5'd3},  5'd0);
        offset1 = 5'b11101;
        single_conv(5'd10, {5'd16, 5'd8,  5'd12, 5'd10, 5'd11}, 5'd7);
        offset1 = 5'd0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
